clk_en_gen: RTL and testbench
=============================

# clk_en_gen

Parametrised multi-channel clock-enable generator on the 50 MHz system clock. Each of N_CH channels divides clk_50M by a runtime-programmable count and emits a one-cycle enable tick plus a 50 %-duty square output. Divisor changes are double-buffered and applied glitch-free at period boundaries. A global sync input phase-aligns all channels. Downstream counters, samplers and display scanners use it in place of per-block fixed dividers.

## Interface
Parameters:
- N_CH, 4, number of independent channels
- CNT_W, 19, counter and divisor width
- DEF_DIV, 49_999, reset divisor for every channel (1 kHz ticks at 50 MHz); must be < 2^CNT_W

Ports:
- clk_50M  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- en  in  N_CH  per-channel run enable
- div_in  in  N_CH*CNT_W  divisor per channel; channel i uses bits [i*CNT_W +: CNT_W]; period = div+1 cycles
- load  in  N_CH  per-channel strobe that captures the div_in slice
- sync  in  1  restarts all channels in phase
- tick  out  N_CH  registered one-cycle enable pulse per period
- sq  out  N_CH  registered square wave, toggles on every tick
- pend  out  N_CH  shadow divisor captured but not yet applied

## Operation
Per-channel state: cnt[CNT_W], div_act, div_sh, pend, tick, sq.

Priority at each rising edge, per channel, highest first:
- sync=1: cnt<=0, tick<=0, sq<=0. div_act takes div_in if load[i]=1, otherwise div_sh if pend=1. pend<=0. Applies to all channels regardless of en.
- en[i]=0 (idle): cnt<=0, tick<=0, sq<=0. load[i] writes div_in directly to div_act and div_sh, and pend stays 0. A pending shadow is applied now.
- en[i]=1 and cnt==div_act (terminal): cnt<=0, tick<=1, sq<=~sq. div_act takes div_in if load[i]=1, else div_sh if pend=1. pend<=0.
- en[i]=1 otherwise: cnt<=cnt+1, tick<=0. load[i] sets div_sh<=div_in and pend<=1. A repeated load overwrites the shadow; the last value wins.

Other rules:
- div_act=0 gives terminal on every enabled edge, so tick is held at 1 and sq toggles every cycle.
- cnt never exceeds div_act. A shrinking divisor only takes effect at a terminal, so no wrap-around through 2^CNT_W is possible.
- Channels are fully independent except for the shared sync input.

## Timing
- Reset (async, immediate, no clock needed): cnt=0, tick=0, sq=0, pend=0, div_act=div_sh=DEF_DIV for all channels.
- Take edge 1 as the first edge sampling en=1 with cnt=0:
  - The first tick is registered at edge div_act+1 and is high for exactly one cycle.
  - Subsequent ticks follow every div_act+1 edges.
  - sq period is 2*(div_act+1) cycles.
- A load while running: pend goes high the edge after the load edge and clears at the next terminal edge. The new period starts counting from that terminal.
- A load coinciding with a terminal, sync or idle edge: the new divisor governs the very next period, and pend never asserts.
- en deasserted mid-period: tick and sq are 0 after the next edge, and the partial count is discarded.
- After a sync edge, every enabled channel behaves as if enabled at the following edge, so ticks of channels with equal div_act coincide exactly.
- All outputs are direct flop outputs, with no combinational path from inputs.

## Test plan
1. Reset, en[0]=1, divisor 3 → tick[0] high after edges 4, 8, 12 (one cycle each); sq[0] rises at edge 4 and falls at edge 8; pend=0; other channels stay 0.
2. Divisor 0 on ch1 with en[1]=1 → tick[1] continuously 1 from edge 1; sq[1] toggles every cycle; deasserting en[1] gives tick=sq=0 one edge later.
3. Ch0 running at divisor 9; load 4 when cnt=2 → pend=1 until the tick at cnt 9, then ticks every 5 cycles; a second load of 6 before that terminal makes the period 7 instead.
4. Ch0 divisor 3 and ch2 divisor 3 enabled at different times; pulse sync → both restart at cnt 0, and both ticks coincide at sync+4, sync+8; sq of both restart at 0.
5. Load asserted on the exact terminal edge with div_in=1 → following ticks every 2 cycles immediately; pend never asserts.
6. rst_n pulled low between edges mid-count with pend=1 → tick, sq and pend drop to 0 without a clock edge; after release, the period is DEF_DIV+1 = 50 000 cycles.

Source files
------------

// File: rtl/clk_en_gen_if.sv
// Control/status bundle for the multi-channel clock-enable generator.
// The master drives enables, divisors and strobes; the slave returns the registered outputs.
interface clk_en_gen_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 19
);
    logic [N_CH-1:0]       en;
    logic [N_CH*CNT_W-1:0] div_in;
    logic [N_CH-1:0]       load;
    logic                  sync;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       sq;
    logic [N_CH-1:0]       pend;

    modport master (output en, div_in, load, sync, input  tick, sq, pend);
    modport slave  (input  en, div_in, load, sync, output tick, sq, pend);
endinterface

// File: rtl/clk_en_gen.sv
// N_CH independent programmable dividers on clk_50M, each emitting a one-cycle tick
// and a 50%-duty square wave; divisor updates are shadowed and applied at period boundaries.
module clk_en_ch #(
    parameter int CNT_W   = 19,
    parameter int DEF_DIV = 49_999
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             load,
    input  logic             sync,
    output logic             tick,
    output logic             sq,
    output logic             pend
);
    logic [CNT_W-1:0] cnt, div_act, div_sh, nxt_div;

    // Divisor that takes over at a boundary: a same-edge load beats a pending shadow.
    always_comb begin
        nxt_div = div_act;
        if (load)      nxt_div = div_in;
        else if (pend) nxt_div = div_sh;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_act <= CNT_W'(DEF_DIV);
            div_sh  <= CNT_W'(DEF_DIV);
            pend    <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
        end else if (sync || !en) begin
            cnt     <= '0;
            tick    <= 1'b0;
            sq      <= 1'b0;
            div_act <= nxt_div;
            div_sh  <= nxt_div;
            pend    <= 1'b0;
        end else if (cnt == div_act) begin
            cnt     <= '0;
            tick    <= 1'b1;
            sq      <= ~sq;
            div_act <= nxt_div;
            div_sh  <= nxt_div;
            pend    <= 1'b0;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
            // Mid-period loads only park in the shadow; last one wins.
            if (load) begin
                div_sh <= div_in;
                pend   <= 1'b1;
            end
        end
    end
endmodule

module clk_en_gen #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 19,
    parameter int DEF_DIV = 49_999
) (
    input  logic         clk_50M,
    input  logic         rst_n,
    clk_en_gen_if.slave  bus
);
    logic [N_CH-1:0] tick_w, sq_w, pend_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_en_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
            .clk_50M (clk_50M),
            .rst_n   (rst_n),
            .en      (bus.en[i]),
            .div_in  (bus.div_in[i*CNT_W +: CNT_W]),
            .load    (bus.load[i]),
            .sync    (bus.sync),
            .tick    (tick_w[i]),
            .sq      (sq_w[i]),
            .pend    (pend_w[i])
        );
    end

    assign bus.tick = tick_w;
    assign bus.sq   = sq_w;
    assign bus.pend = pend_w;
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: hand-computed tick/sq/pend sequences per edge.
module tb_clk_en_gen;
    localparam int N_CH  = 4;
    localparam int CNT_W = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    clk_en_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    clk_en_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(49_999)) dut (
        .clk_50M (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Inputs set before step() are sampled at its edge; outputs are read 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int ch, input int val);
        bus.div_in[ch*CNT_W +: CNT_W] = CNT_W'(val);
        bus.load[ch] = 1'b1;
        step();
        bus.load[ch] = 1'b0;
    endtask

    initial begin
        int n;
        bus.en = '0; bus.load = '0; bus.sync = 1'b0; bus.div_in = '0;
        step(); step();
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_sq",   32'(bus.sq),   0);
        chk("rst_pend", 32'(bus.pend), 0);
        rst_n = 1'b1;

        // 1: ch0 divisor 3
        set_div(0, 3);
        bus.en[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("t1_tick_e%0d", e), 32'(bus.tick), (e % 4 == 0) ? 1 : 0);
            chk($sformatf("t1_sq_e%0d", e),   32'(bus.sq),   (e / 4) & 1);
        end
        chk("t1_pend", 32'(bus.pend), 0);
        bus.en[0] = 1'b0;
        step();
        chk("t1_off_tick", 32'(bus.tick), 0);
        chk("t1_off_sq",   32'(bus.sq),   0);

        // 2: ch1 divisor 0
        set_div(1, 0);
        bus.en[1] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk($sformatf("t2_tick_e%0d", e), 32'(bus.tick[1]), 1);
            chk($sformatf("t2_sq_e%0d", e),   32'(bus.sq[1]),   e & 1);
        end
        bus.en[1] = 1'b0;
        step();
        chk("t2_off_tick", 32'(bus.tick[1]), 0);
        chk("t2_off_sq",   32'(bus.sq[1]),   0);

        // 3: ch0 divisor 9, shadow load of 4 at cnt=2, then overwritten load 2 -> 6
        set_div(0, 9);
        bus.en[0] = 1'b1;
        step(); step();
        bus.div_in[0 +: CNT_W] = CNT_W'(4); bus.load[0] = 1'b1;
        step();
        bus.load[0] = 1'b0;
        chk("t3_pend_set", 32'(bus.pend[0]), 1);
        for (int e = 4; e <= 20; e++) begin
            step();
            chk($sformatf("t3_tick_e%0d", e), 32'(bus.tick[0]), (e == 10 || e == 15 || e == 20) ? 1 : 0);
            if (e == 9)  chk("t3_pend_hold", 32'(bus.pend[0]), 1);
            if (e == 10) chk("t3_pend_clr",  32'(bus.pend[0]), 0);
        end
        bus.div_in[0 +: CNT_W] = CNT_W'(2); bus.load[0] = 1'b1;
        step();
        bus.div_in[0 +: CNT_W] = CNT_W'(6);
        step();
        bus.load[0] = 1'b0;
        chk("t3_pend_2nd", 32'(bus.pend[0]), 1);
        for (int e = 23; e <= 39; e++) begin
            step();
            chk($sformatf("t3b_tick_e%0d", e), 32'(bus.tick[0]), (e == 25 || e == 32 || e == 39) ? 1 : 0);
        end
        bus.en[0] = 1'b0;
        step();

        // 4: sync aligns ch0 and ch2
        set_div(0, 3);
        set_div(2, 3);
        bus.en[0] = 1'b1;
        repeat (5) step();
        chk("t4_pre_sq0", 32'(bus.sq[0]), 1);
        bus.en[2] = 1'b1;
        step(); step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        chk("t4_sync_tick", 32'(bus.tick), 0);
        chk("t4_sync_sq",   32'(bus.sq),   0);
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("t4_tick_e%0d", e), 32'(bus.tick), (e % 4 == 0) ? 5 : 0);
            chk($sformatf("t4_sq_e%0d", e),   32'(bus.sq),   ((e / 4) & 1) ? 5 : 0);
        end
        bus.en = '0;
        step();

        // 5: load coinciding with a terminal edge
        set_div(3, 5);
        bus.en[3] = 1'b1;
        repeat (5) step();
        bus.div_in[3*CNT_W +: CNT_W] = CNT_W'(1); bus.load[3] = 1'b1;
        step();
        bus.load[3] = 1'b0;
        chk("t5_term_tick", 32'(bus.tick[3]), 1);
        chk("t5_term_pend", 32'(bus.pend[3]), 0);
        for (int e = 7; e <= 12; e++) begin
            step();
            chk($sformatf("t5_tick_e%0d", e), 32'(bus.tick[3]), (e % 2 == 0) ? 1 : 0);
            chk($sformatf("t5_pend_e%0d", e), 32'(bus.pend[3]), 0);
        end
        bus.en = '0;
        step();

        // 6: async reset mid-count with pend set, then default period
        set_div(0, 9);
        set_div(1, 0);
        bus.en[0] = 1'b1; bus.en[1] = 1'b1;
        step(); step();
        bus.div_in[0 +: CNT_W] = CNT_W'(4); bus.load[0] = 1'b1;
        step();
        bus.load[0] = 1'b0;
        chk("t6_pre_pend", 32'(bus.pend[0]), 1);
        chk("t6_pre_tick", 32'(bus.tick[1]), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_tick", 32'(bus.tick), 0);
        chk("t6_rst_sq",   32'(bus.sq),   0);
        chk("t6_rst_pend", 32'(bus.pend), 0);
        bus.en[1] = 1'b0;
        #2 rst_n = 1'b1;
        n = 0;
        while (n < 60000) begin
            step();
            n++;
            if (bus.tick[0]) break;
        end
        chk("t6_def_period", 32'(n), 50000);
        step();
        chk("t6_tick_one_cycle", 32'(bus.tick[0]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
